// File: rtl/regfile_pkg.sv
// Shared parameter defaults and legal limits for the multi-port register file.
package regfile_pkg;

    localparam int RF_DATA_W_DEF   = 8;
    localparam int RF_ADDR_W_DEF   = 4;
    localparam int RF_NUM_RD_DEF   = 2;
    localparam bit RF_ZERO_REG_DEF = 1'b0;

    localparam int RF_DATA_W_MIN = 1;
    localparam int RF_DATA_W_MAX = 64;
    localparam int RF_ADDR_W_MIN = 1;
    localparam int RF_ADDR_W_MAX = 10;
    localparam int RF_NUM_RD_MIN = 1;
    localparam int RF_NUM_RD_MAX = 8;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: write-first bypass mux, data register and rvalid flop.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter bit ZERO_REG = RF_ZERO_REG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_waddr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_waddr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
);

    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic [DATA_W-1:0] w_next;

    // Port 1 is checked last so it wins when both writes hit the read address.
    always_comb begin
        w_next = i_mem_data;
        if (i_we0 && (i_waddr0 == i_raddr)) w_next = i_wdata0;
        if (i_we1 && (i_waddr1 == i_raddr)) w_next = i_wdata1;
        if (ZERO_REG && (i_raddr == '0))    w_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= i_re;
            if (i_re) r_rdata <= w_next;
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;

endmodule

// File: rtl/regfile_mp.sv
// Register file with two prioritised write ports and NUM_RD independent registered read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int NUM_RD   = RF_NUM_RD_DEF,
    parameter bit ZERO_REG = RF_ZERO_REG_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rvalid,
    output logic [(1<<ADDR_W)-1:0]   entry_valid,
    output logic                     wr_conflict
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_entry_valid;
    logic              r_wr_conflict;
    logic              w_we0;
    logic              w_we1;
    logic              w_conflict;

    // Writes to a hardwired-zero entry vanish before bypass and conflict detection.
    assign w_we0      = we0 && !(ZERO_REG && (waddr0 == '0));
    assign w_we1      = we1 && !(ZERO_REG && (waddr1 == '0));
    assign w_conflict = w_we0 && w_we1 && (waddr0 == waddr1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_entry_valid <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            if (w_we0) begin
                r_mem[waddr0]         <= wdata0;
                r_entry_valid[waddr0] <= 1'b1;
            end
            if (w_we1) begin
                r_mem[waddr1]         <= wdata1;
                r_entry_valid[waddr1] <= 1'b1;
            end
            r_wr_conflict <= w_conflict;
        end
    end

    if (ZERO_REG) begin : g_zero_valid
        assign entry_valid = r_entry_valid | DEPTH'(1);
    end else begin : g_plain_valid
        assign entry_valid = r_entry_valid;
    end

    assign wr_conflict = r_wr_conflict;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        assign w_raddr = raddr[g*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_re       (re[g]),
            .i_raddr    (w_raddr),
            .i_mem_data (r_mem[w_raddr]),
            .i_we0      (w_we0),
            .i_waddr0   (waddr0),
            .i_wdata0   (wdata0),
            .i_we1      (w_we1),
            .i_waddr1   (waddr1),
            .i_wdata1   (wdata1),
            .o_rdata    (rdata[g*DATA_W +: DATA_W]),
            .o_rvalid   (rvalid[g])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance and a ZERO_REG instance share stimulus, each with its own reference model.
module tb_regfile_mp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we0, we1;
    logic [3:0] waddr0, waddr1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] re;
    logic [7:0] raddr;

    logic [15:0] rdata_o  [2];
    logic [1:0]  rvalid_o [2];
    logic [15:0] ev_o     [2];
    logic        conf_o   [2];

    // Reference model: index 0 = plain instance, index 1 = ZERO_REG instance.
    logic [7:0]  m_mem      [2][16];
    logic [15:0] m_ev       [2];
    logic [15:0] exp_rdata  [2];
    logic [1:0]  exp_rvalid [2];
    logic        exp_conf   [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr),
        .rdata(rdata_o[0]), .rvalid(rvalid_o[0]),
        .entry_valid(ev_o[0]), .wr_conflict(conf_o[0])
    );

    regfile_mp #(.ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr),
        .rdata(rdata_o[1]), .rvalid(rvalid_o[1]),
        .entry_valid(ev_o[1]), .wr_conflict(conf_o[1])
    );

    task automatic idle_inputs();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        re = '0; raddr = '0;
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int a = 0; a < 16; a++) m_mem[z][a] = 8'h00;
            m_ev[z]       = (z == 1) ? 16'h0001 : 16'h0000;
            exp_rdata[z]  = 16'h0000;
            exp_rvalid[z] = 2'b00;
            exp_conf[z]   = 1'b0;
        end
    endtask

    // Writes land first (port 1 last, so it wins), then reads see the updated array.
    task automatic model_edge();
        bit         e0, e1;
        logic [3:0] ra;
        for (int z = 0; z < 2; z++) begin
            e0 = we0 && !(z == 1 && waddr0 == 4'd0);
            e1 = we1 && !(z == 1 && waddr1 == 4'd0);
            exp_conf[z] = e0 && e1 && (waddr0 == waddr1);
            if (e0) begin m_mem[z][waddr0] = wdata0; m_ev[z][waddr0] = 1'b1; end
            if (e1) begin m_mem[z][waddr1] = wdata1; m_ev[z][waddr1] = 1'b1; end
            for (int i = 0; i < 2; i++) begin
                exp_rvalid[z][i] = re[i];
                if (re[i]) begin
                    ra = raddr[i*4 +: 4];
                    exp_rdata[z][i*8 +: 8] = (z == 1 && ra == 4'd0) ? 8'h00 : m_mem[z][ra];
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        for (int z = 0; z < 2; z++) begin
            checks += 4;
            if (rdata_o[z] !== 16'h0) begin failures++; $display("FAIL reset_rdata z=%0d got=%h exp=0000", z, rdata_o[z]); end
            if (rvalid_o[z] !== 2'b00) begin failures++; $display("FAIL reset_rvalid z=%0d got=%b exp=00", z, rvalid_o[z]); end
            if (ev_o[z] !== ((z == 1) ? 16'h0001 : 16'h0000)) begin failures++; $display("FAIL reset_ev z=%0d got=%h", z, ev_o[z]); end
            if (conf_o[z] !== 1'b0) begin failures++; $display("FAIL reset_conf z=%0d got=%b exp=0", z, conf_o[z]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            re = 2'b11;
            raddr = {a[3:0], a[3:0]};
            step();
            for (int z = 0; z < 2; z++) begin
                checks += 3;
                if (rdata_o[z] !== 16'h0) begin failures++; $display("FAIL empty_read z=%0d a=%0d got=%h exp=0000", z, a, rdata_o[z]); end
                if (rvalid_o[z] !== 2'b11) begin failures++; $display("FAIL empty_rvalid z=%0d got=%b exp=11", z, rvalid_o[z]); end
                if (ev_o[z] !== ((z == 1) ? 16'h0001 : 16'h0000)) begin failures++; $display("FAIL empty_ev z=%0d got=%h", z, ev_o[z]); end
            end
        end
        idle_inputs();
        step();
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (rvalid_o[z] !== 2'b00) begin failures++; $display("FAIL rvalid_drop z=%0d got=%b exp=00", z, rvalid_o[z]); end
        end
    endtask

    task automatic test_write_read();
        idle_inputs();
        we0 = 1'b1; waddr0 = 4'd3; wdata0 = 8'hA5;
        step();
        idle_inputs();
        re = 2'b01; raddr = 8'h03;
        step();
        for (int z = 0; z < 2; z++) begin
            checks += 3;
            if (ev_o[z][3] !== 1'b1) begin failures++; $display("FAIL wr_ev3 z=%0d got=%b exp=1", z, ev_o[z][3]); end
            if (rdata_o[z][7:0] !== 8'hA5) begin failures++; $display("FAIL wr_read3 z=%0d got=%h exp=a5", z, rdata_o[z][7:0]); end
            if (rvalid_o[z] !== 2'b01) begin failures++; $display("FAIL wr_rvalid z=%0d got=%b exp=01", z, rvalid_o[z]); end
        end
    endtask

    task automatic test_conflict();
        idle_inputs();
        we0 = 1'b1; waddr0 = 4'd5; wdata0 = 8'h11;
        we1 = 1'b1; waddr1 = 4'd5; wdata1 = 8'h22;
        step();
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (conf_o[z] !== 1'b1) begin failures++; $display("FAIL conflict_pulse z=%0d got=%b exp=1", z, conf_o[z]); end
        end
        idle_inputs();
        re = 2'b10; raddr = 8'h50;
        step();
        for (int z = 0; z < 2; z++) begin
            checks += 2;
            if (conf_o[z] !== 1'b0) begin failures++; $display("FAIL conflict_end z=%0d got=%b exp=0", z, conf_o[z]); end
            if (rdata_o[z][15:8] !== 8'h22) begin failures++; $display("FAIL conflict_data z=%0d got=%h exp=22", z, rdata_o[z][15:8]); end
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        we0 = 1'b1; waddr0 = 4'd7; wdata0 = 8'h3C;
        re = 2'b10; raddr = 8'h70;
        step();
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (rdata_o[z][15:8] !== 8'h3C) begin failures++; $display("FAIL bypass_p0 z=%0d got=%h exp=3c", z, rdata_o[z][15:8]); end
        end
        idle_inputs();
        we0 = 1'b1; waddr0 = 4'd9; wdata0 = 8'hAA;
        we1 = 1'b1; waddr1 = 4'd9; wdata1 = 8'hBB;
        re = 2'b11; raddr = 8'h99;
        step();
        for (int z = 0; z < 2; z++) begin
            checks++;
            if (rdata_o[z] !== 16'hBBBB) begin failures++; $display("FAIL bypass_prio z=%0d got=%h exp=bbbb", z, rdata_o[z]); end
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        we0 = 1'b1; waddr0 = 4'd0; wdata0 = 8'hFF;
        we1 = 1'b1; waddr1 = 4'd0; wdata1 = 8'h77;
        re = 2'b01; raddr = 8'h00;
        step();
        for (int z = 0; z < 2; z++) begin
            checks += 2;
            if (rdata_o[z][7:0] !== ((z == 1) ? 8'h00 : 8'h77)) begin failures++; $display("FAIL zero_bypass z=%0d got=%h", z, rdata_o[z][7:0]); end
            if (conf_o[z] !== (z == 0)) begin failures++; $display("FAIL zero_conflict z=%0d got=%b", z, conf_o[z]); end
        end
        idle_inputs();
        re = 2'b11; raddr = 8'h00;
        step();
        for (int z = 0; z < 2; z++) begin
            checks += 2;
            if (rdata_o[z] !== ((z == 1) ? 16'h0000 : 16'h7777)) begin failures++; $display("FAIL zero_read z=%0d got=%h", z, rdata_o[z]); end
            if (ev_o[z][0] !== 1'b1) begin failures++; $display("FAIL zero_ev z=%0d got=%b exp=1", z, ev_o[z][0]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            waddr0 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            waddr1 = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            re = 2'($urandom_range(0, 3));
            raddr = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3))};
            step();
            for (int z = 0; z < 2; z++) begin
                checks += 4;
                if (rdata_o[z] !== exp_rdata[z]) begin failures++; $display("FAIL rnd_rdata n=%0d z=%0d got=%h exp=%h", n, z, rdata_o[z], exp_rdata[z]); end
                if (rvalid_o[z] !== exp_rvalid[z]) begin failures++; $display("FAIL rnd_rvalid n=%0d z=%0d got=%b exp=%b", n, z, rvalid_o[z], exp_rvalid[z]); end
                if (ev_o[z] !== m_ev[z]) begin failures++; $display("FAIL rnd_ev n=%0d z=%0d got=%h exp=%h", n, z, ev_o[z], m_ev[z]); end
                if (conf_o[z] !== exp_conf[z]) begin failures++; $display("FAIL rnd_conf n=%0d z=%0d got=%b exp=%b", n, z, conf_o[z], exp_conf[z]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int a = 0; a < 16; a++) begin
            idle_inputs();
            we0 = 1'b1; waddr0 = a[3:0]; wdata0 = 8'($urandom_range(1, 255));
            if (a == 15) begin we1 = 1'b1; waddr1 = 4'd15; wdata1 = 8'h5A; end
            re = 2'b11; raddr = {4'($urandom_range(0, 15)), a[3:0]};
            step();
        end
        checks++;
        if (conf_o[0] !== 1'b1) begin failures++; $display("FAIL mid_conf_pending got=%b exp=1", conf_o[0]); end
        re = 2'b11; we1 = 1'b1; waddr1 = 4'd2; wdata1 = 8'hC3;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int z = 0; z < 2; z++) begin
            checks += 4;
            if (rdata_o[z] !== 16'h0) begin failures++; $display("FAIL mid_rdata z=%0d got=%h exp=0000", z, rdata_o[z]); end
            if (rvalid_o[z] !== 2'b00) begin failures++; $display("FAIL mid_rvalid z=%0d got=%b exp=00", z, rvalid_o[z]); end
            if (ev_o[z] !== m_ev[z]) begin failures++; $display("FAIL mid_ev z=%0d got=%h exp=%h", z, ev_o[z], m_ev[z]); end
            if (conf_o[z] !== 1'b0) begin failures++; $display("FAIL mid_conf z=%0d got=%b exp=0", z, conf_o[z]); end
        end
        @(posedge clk);
        #1;
        for (int z = 0; z < 2; z++) begin
            checks += 2;
            if (rvalid_o[z] !== 2'b00) begin failures++; $display("FAIL held_rvalid z=%0d got=%b exp=00", z, rvalid_o[z]); end
            if (ev_o[z] !== m_ev[z]) begin failures++; $display("FAIL held_ev z=%0d got=%h exp=%h", z, ev_o[z], m_ev[z]); end
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            re = 2'b11;
            raddr = {4'(15 - a), a[3:0]};
            step();
            for (int z = 0; z < 2; z++) begin
                checks += 2;
                if (rdata_o[z] !== 16'h0) begin failures++; $display("FAIL post_reset_read z=%0d a=%0d got=%h exp=0000", z, a, rdata_o[z]); end
                if (ev_o[z] !== m_ev[z]) begin failures++; $display("FAIL post_reset_ev z=%0d got=%h exp=%h", z, ev_o[z], m_ev[z]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_bypass();
        test_zero_reg();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
